// File: rtl/spike_decoder.sv
`default_nettype none
// ============================================================================
// Module   : spike_decoder
// Purpose  : Rebuilds an amplitude level from up/down spike trains and emits
//            periodic level snapshots on a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
module spike_decoder #(
    parameter int unsigned CLK_DIV       = 1200000,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned DEFAULT_LEVEL = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              spike_up_i,
    input  logic              spike_dn_i,
    input  logic [DATA_W-1:0] delta_i,
    output logic [DATA_W-1:0] level_o,
    output logic [DATA_W-1:0] sample_o,
    output logic              sample_valid_o,
    input  logic              sample_ready_i,
    output logic              sat_o,
    output logic              drop_o
);

    localparam int unsigned       CNT_W     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0]  C_CNT_MAX = CNT_W'(CLK_DIV - 1);
    localparam logic [DATA_W-1:0] C_LVL_RST = DATA_W'(DEFAULT_LEVEL);
    localparam logic [DATA_W-1:0] C_LVL_MAX = '1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_level;
    logic [DATA_W-1:0] r_sample;
    logic              r_sat;
    logic              r_drop;

    logic              w_tick;
    logic              w_up;
    logic              w_dn;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;

    assign w_tick = en_i && (r_cnt == C_CNT_MAX);
    assign w_up   = en_i && spike_up_i && !spike_dn_i;
    assign w_dn   = en_i && spike_dn_i && !spike_up_i;
    // The extra MSB is the carry on add and the borrow on subtract.
    assign w_sum  = {1'b0, r_level} + {1'b0, delta_i};
    assign w_diff = {1'b0, r_level} - {1'b0, delta_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (!en_i || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_level <= C_LVL_RST;
            r_sat   <= 1'b0;
        end else if (w_up) begin
            if (w_sum[DATA_W]) begin
                r_level <= C_LVL_MAX;
                r_sat   <= 1'b1;
            end else begin
                r_level <= w_sum[DATA_W-1:0];
            end
        end else if (w_dn) begin
            if (w_diff[DATA_W]) begin
                r_level <= '0;
                r_sat   <= 1'b1;
            end else begin
                r_level <= w_diff[DATA_W-1:0];
            end
        end
    end

    // Snapshot takes the pre-update level; a tick while the consumer stalls
    // keeps the old sample and flags the loss.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_sample <= '0;
            r_drop   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_sample <= r_level;
                        r_state  <= S_PEND;
                    end
                end
                S_PEND: begin
                    if (sample_ready_i) begin
                        if (w_tick) begin
                            r_sample <= r_level;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (w_tick) begin
                        r_drop <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign level_o        = r_level;
    assign sample_o       = r_sample;
    assign sample_valid_o = (r_state == S_PEND);
    assign sat_o          = r_sat;
    assign drop_o         = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_spike_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spike_decoder
// Purpose  : Randomised and directed self-checking bench for spike_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spike_decoder;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned DEF_LVL = 10;
    localparam int          LMAX    = 255;

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b0;
    logic              en      = 1'b0;
    logic              up      = 1'b0;
    logic              dn      = 1'b0;
    logic              rdy     = 1'b1;
    logic [DATA_W-1:0] delta   = '0;
    logic [DATA_W-1:0] level;
    logic [DATA_W-1:0] sample;
    logic              valid;
    logic              sat;
    logic              drop;

    spike_decoder #(
        .CLK_DIV       (CLK_DIV),
        .DATA_W        (DATA_W),
        .DEFAULT_LEVEL (DEF_LVL)
    ) u_dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .en_i           (en),
        .spike_up_i     (up),
        .spike_dn_i     (dn),
        .delta_i        (delta),
        .level_o        (level),
        .sample_o       (sample),
        .sample_valid_o (valid),
        .sample_ready_i (rdy),
        .sat_o          (sat),
        .drop_o         (drop)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: plain integers, updated from the behavioural rules.
    int m_level, m_cnt, m_sample;
    bit m_valid, m_sat, m_drop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_level  = DEF_LVL;
        m_cnt    = 0;
        m_sample = 0;
        m_valid  = 1'b0;
        m_sat    = 1'b0;
        m_drop   = 1'b0;
    endtask

    task automatic model_step(input bit e, input bit u, input bit d, input int dl, input bit r);
        bit tick;
        int old_level;
        tick      = e && (m_cnt == CLK_DIV - 1);
        old_level = m_level;
        m_cnt     = (!e || tick) ? 0 : m_cnt + 1;
        if (e && u && !d) begin
            m_level = m_level + dl;
            if (m_level > LMAX) begin m_level = LMAX; m_sat = 1'b1; end
        end else if (e && d && !u) begin
            m_level = m_level - dl;
            if (m_level < 0) begin m_level = 0; m_sat = 1'b1; end
        end
        if (!m_valid) begin
            if (tick) begin m_valid = 1'b1; m_sample = old_level; end
        end else if (r) begin
            if (tick) m_sample = old_level;
            else      m_valid  = 1'b0;
        end else if (tick) begin
            m_drop = 1'b1;
        end
    endtask

    task automatic check_all();
        check("level",  32'(level),  32'(m_level));
        check("valid",  32'(valid),  32'(m_valid));
        if (m_valid) check("sample", 32'(sample), 32'(m_sample));
        check("sat",    32'(sat),    32'(m_sat));
        check("drop",   32'(drop),   32'(m_drop));
    endtask

    task automatic cycle(input bit u, input bit d, input int dl, input bit e, input bit r);
        en    = e;
        up    = u;
        dn    = d;
        delta = DATA_W'(dl);
        rdy   = r;
        @(posedge clk);
        if (rst_n) model_step(e, u, d, dl, r);
        #1;
        check_all();
    endtask

    initial begin
        int pulses;
        int frozen;
        int held;
        int guard;
        bit e_r, r_r;
        int dl_r;

        // 1. Reset values and idle sampling cadence
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        check("rst_sample", 32'(sample), 0);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(0, 0, 0, 1, 1);
            if (valid) pulses++;
            check("idle_smp", 32'(valid ? sample : 8'(DEF_LVL)), DEF_LVL);
        end
        check("pulses", 32'(pulses), 3);

        // 2. Accumulate
        cycle(1, 0, 5, 1, 1); check("acc0", 32'(level), 15);
        cycle(1, 0, 5, 1, 1); check("acc1", 32'(level), 20);
        cycle(0, 1, 5, 1, 1); check("acc2", 32'(level), 15);
        cycle(1, 1, 5, 1, 1); check("acc3", 32'(level), 15);
        repeat (4) cycle(0, 0, 0, 1, 1);

        // 3. Saturate high then low, plus a zero delta
        cycle(1, 0, 235, 1, 1); check("to250", 32'(level), 250);
        cycle(1, 0, 0, 1, 1);   check("zero_d", 32'(sat), 0);
        cycle(1, 0, 10, 1, 1);  check("sat_hi", 32'(level), 255);
        check("sat_hi_f", 32'(sat), 1);
        cycle(0, 1, 252, 1, 1); check("to3", 32'(level), 3);
        cycle(0, 1, 5, 1, 1);   check("sat_lo", 32'(level), 0);
        check("sat_lo_f", 32'(sat), 1);
        cycle(1, 0, 40, 1, 1);

        // 4. Back-pressure: hold the first sample, then flag the second tick
        guard = 0;
        while (!valid && guard < 20) begin cycle(0, 0, 0, 1, 0); guard++; end
        check("bp_wait", 32'(valid), 1);
        held = sample;
        for (int i = 0; i < 10; i++) begin
            cycle(i % 2, 0, 3, 1, 0);
            check("bp_hold", 32'(sample), 32'(held));
        end
        check("bp_drop", 32'(drop), 1);
        guard = 0;
        while (m_cnt != CLK_DIV - 1 && guard < 20) begin cycle(0, 0, 0, 1, 0); guard++; end
        check("bp_align", 32'(m_cnt), CLK_DIV - 1);
        frozen = level;
        cycle(0, 0, 0, 1, 1);
        check("bp_reload_v", 32'(valid), 1);
        check("bp_reload_s", 32'(sample), 32'(frozen));
        cycle(0, 0, 0, 1, 1);

        // 5. Enable gating
        cycle(0, 0, 0, 1, 1);
        frozen = level;
        for (int i = 0; i < 5; i++) begin
            cycle(i % 2, (i + 1) % 2, 7, 0, 1);
            check("en_frz", 32'(level), 32'(frozen));
        end
        for (int i = 1; i <= 4; i++) begin
            cycle(0, 0, 0, 1, 1);
            check("en_tick", 32'(valid), 32'(i == 4));
        end

        // 6. Asynchronous reset while a sample is pending
        guard = 0;
        while (!valid && guard < 20) begin cycle(1, 0, 9, 1, 0); guard++; end
        check("ar_wait", 32'(valid), 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("ar_valid", 32'(valid), 0);
        check("ar_level", 32'(level), DEF_LVL);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic with biased deltas and occasional enable/ready drops
        for (int i = 0; i < 1500; i++) begin
            e_r = ($urandom_range(0, 9) != 0);
            r_r = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 4))
                0:       dl_r = 0;
                1:       dl_r = 255;
                2:       dl_r = $urandom_range(100, 255);
                default: dl_r = $urandom_range(0, 20);
            endcase
            cycle($urandom_range(0, 1), $urandom_range(0, 1), dl_r, e_r, r_r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
